// File: rtl/hdmi_tmds_encoder.sv
// TMDS transmit encoder for one DVI/HDMI channel: 8-bit pixel component + 2 control bits -> 10-bit character.
// Define TMDS_GUARDBAND_EN to add two stages that insert the video guard band ahead of each data period.
module hdmi_tmds_encoder #(
    parameter int CHANNEL = 0
) (
    input  logic       i_pix_clk,
    input  logic       i_reset_n,
    input  logic       i_de,
    input  logic [1:0] i_ctl,
    input  logic [7:0] i_data,
    output logic [9:0] o_word
);

    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

    // The encoding value doubles as q_m[8].
    typedef enum logic {
        MODE_XNOR = 1'b0,
        MODE_XOR  = 1'b1
    } qm_mode_e;

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] ctl);
        logic [9:0] sym;
        case (ctl)
            2'b00:   sym = CTRL_00;
            2'b01:   sym = CTRL_01;
            2'b10:   sym = CTRL_10;
            default: sym = CTRL_11;
        endcase
        return sym;
    endfunction

    // ---------------- Stage 1: transition minimisation ----------------
    logic [3:0] data_ones;
    qm_mode_e   mode;
    logic       chain;
    logic [8:0] q_m_next;
    logic [3:0] q_m_ones_next;

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        data_ones = '0;
        for (int i = 0; i < 8; i++) begin
            data_ones = data_ones + {3'b000, i_data[i]};
        end
        mode = ((data_ones > 4'd4) || (data_ones == 4'd4 && !i_data[0])) ? MODE_XNOR : MODE_XOR;

        q_m_next    = '0;
        chain       = i_data[0];
        q_m_next[0] = chain;
        for (int i = 1; i < 8; i++) begin
            chain       = (mode == MODE_XNOR) ? ~(chain ^ i_data[i]) : (chain ^ i_data[i]);
            q_m_next[i] = chain;
        end
        q_m_next[8] = mode;

        q_m_ones_next = '0;
        for (int i = 0; i < 8; i++) begin
            q_m_ones_next = q_m_ones_next + {3'b000, q_m_next[i]};
        end
    end

    logic [8:0] s1_q_m;
    logic [3:0] s1_n1;
    logic [3:0] s1_n0;
    logic       s1_de;
    logic [1:0] s1_ctl;

    // NOTE: state registers use non-blocking assignments so every stage samples the pre-edge values.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_q_m <= '0;
            s1_n1  <= '0;
            s1_n0  <= '0;
            s1_de  <= 1'b0;
            s1_ctl <= 2'b00;
        end else begin
            s1_q_m <= q_m_next;
            s1_n1  <= q_m_ones_next;
            s1_n0  <= 4'd8 - q_m_ones_next;
            s1_de  <= i_de;
            s1_ctl <= i_ctl;
        end
    end

    // ---------------- Stage 2: DC balance ----------------
    logic signed [4:0] cnt;
    logic signed [4:0] cnt_next;
    logic signed [4:0] bal;
    logic        [9:0] s2_word;
    logic        [9:0] s2_word_next;
    logic              q8;
    logic        [7:0] q;

    assign q8  = s1_q_m[8];
    assign q   = s1_q_m[7:0];
    assign bal = $signed({1'b0, s1_n1}) - $signed({1'b0, s1_n0});

    // Control periods force the running disparity back to zero.
    always_comb begin
        s2_word_next = ctrl_symbol(s1_ctl);
        cnt_next     = '0;
        if (s1_de) begin
            if (cnt == 5'sd0 || s1_n1 == s1_n0) begin
                s2_word_next = {~q8, q8, q8 ? q : ~q};
                cnt_next     = q8 ? (cnt + bal) : (cnt - bal);
            end else if ((cnt > 5'sd0 && s1_n1 > s1_n0) || (cnt < 5'sd0 && s1_n0 > s1_n1)) begin
                s2_word_next = {1'b1, q8, ~q};
                cnt_next     = cnt + (q8 ? 5'sd2 : 5'sd0) - bal;
            end else begin
                s2_word_next = {1'b0, q8, q};
                cnt_next     = cnt - (q8 ? 5'sd0 : 5'sd2) + bal;
            end
        end
    end

    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s2_word <= CTRL_00;
            cnt     <= '0;
        end else begin
            s2_word <= s2_word_next;
            cnt     <= cnt_next;
        end
    end

`ifdef TMDS_GUARDBAND_EN
    // ---------------- Stages 3-4: guard-band insertion ----------------
    localparam logic [9:0] GUARD_WORD = (CHANNEL == 1) ? 10'h133 : 10'h2CC;

    logic       s2_de;
    logic [9:0] s3_word;
    logic       s3_de;
    logic [9:0] out_word;

    // s3 holds character n; s2 and s1 hold n+1 and n+2, which is the lookahead the guard band needs.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s2_de    <= 1'b0;
            s3_word  <= CTRL_00;
            s3_de    <= 1'b0;
            out_word <= CTRL_00;
        end else begin
            s2_de    <= s1_de;
            s3_word  <= s2_word;
            s3_de    <= s2_de;
            out_word <= (!s3_de && (s2_de || s1_de)) ? GUARD_WORD : s3_word;
        end
    end

    assign o_word = out_word;
`else
    assign o_word = s2_word;

    // CHANNEL only selects the guard band; an out-of-range value leaves this marker scope in the hierarchy.
    if (CHANNEL < 0 || CHANNEL > 2) begin : g_illegal_channel
    end
`endif

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Self-checking bench for hdmi_tmds_encoder: character-level reference model plus directed literal checks.
// Honours TMDS_GUARDBAND_EN (latency 4 and guard-band substitution) when it is defined.
module tb_hdmi_tmds_encoder;

`ifdef TMDS_GUARDBAND_EN
    localparam int         LAT       = 4;
    localparam logic [9:0] GUARD_EXP = 10'h2CC;
`else
    localparam int         LAT       = 2;
    localparam logic [9:0] GUARD_EXP = 10'h354;
`endif
    localparam int HMAX = 1024;

    typedef struct packed {
        logic       de;
        logic [1:0] ctl;
        logic [7:0] data;
    } char_t;

    localparam char_t IDLE = '{de: 1'b0, ctl: 2'b00, data: 8'h00};

    logic       i_pix_clk = 1'b0;
    logic       i_reset_n;
    logic       i_de;
    logic [1:0] i_ctl;
    logic [7:0] i_data;
    logic [9:0] o_word;

    hdmi_tmds_encoder #(.CHANNEL(0)) dut (
        .i_pix_clk (i_pix_clk),
        .i_reset_n (i_reset_n),
        .i_de      (i_de),
        .i_ctl     (i_ctl),
        .i_data    (i_data),
        .o_word    (o_word)
    );

    always #5 i_pix_clk = ~i_pix_clk;

    int         total = 0;
    int         bad   = 0;
    char_t      hist    [HMAX];
    logic [9:0] out_log [HMAX];
    int         e         = 8;
    int         model_cnt = 0;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 10'h%03h, want 10'h%03h", name, act, exp);
        end
    endtask

    // Reference: choose inversion so the character pulls disparity toward zero, then
    // account disparity as (ones - zeros) of the character actually sent.
    function automatic logic [9:0] model_step(input char_t c, input logic de_n1, input logic de_n2);
        logic [8:0] qm;
        logic [9:0] w;
        logic       use_xnor;
        logic       invert;
        int         n1;
        if (!c.de) begin
            model_cnt = 0;
`ifdef TMDS_GUARDBAND_EN
            if (de_n1 || de_n2) return 10'h2CC;
`endif
            case (c.ctl)
                2'b00:   return 10'h354;
                2'b01:   return 10'h0AB;
                2'b10:   return 10'h154;
                default: return 10'h2AB;
            endcase
        end
        use_xnor = ($countones(c.data) > 4) || ($countones(c.data) == 4 && !c.data[0]);
        qm[0] = c.data[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? (qm[i-1] ~^ c.data[i]) : (qm[i-1] ^ c.data[i]);
        qm[8] = !use_xnor;
        n1 = $countones(qm[7:0]);
        if (model_cnt == 0 || n1 == 4) invert = !qm[8];
        else                           invert = ((model_cnt > 0) == (n1 > 4));
        w = {invert, qm[8], invert ? ~qm[7:0] : qm[7:0]};
        model_cnt = model_cnt + 2 * $countones(w) - 10;
        return w;
    endfunction

    // Capture what the DUT sees at each rising edge; reset cycles enter as idle characters.
    always @(posedge i_pix_clk) begin
        hist[e] = i_reset_n ? char_t'{de: i_de, ctl: i_ctl, data: i_data} : IDLE;
        e = e + 1;
    end

    // Reset flushes the characters in flight and clears disparity.
    always @(negedge i_reset_n) begin
        for (int k = 1; k <= LAT; k++) hist[e-k] = IDLE;
        model_cnt = 0;
    end

    always @(negedge i_pix_clk) begin : compare
        int         idx;
        logic [9:0] exp_w;
        idx   = e - LAT;
        exp_w = model_step(hist[idx], hist[idx+1].de, hist[idx+2].de);
        out_log[e-1] = o_word;
        check($sformatf("stream[%0d]", idx), o_word, exp_w);
    end

    task automatic send(input logic de, input logic [1:0] ctl, input logic [7:0] data, output int idx);
        @(posedge i_pix_clk);
        #1;
        i_de   = de;
        i_ctl  = ctl;
        i_data = data;
        idx    = e;
    endtask

    char_t vec [16] = '{
        '{1'b1, 2'd0, 8'h10}, '{1'b1, 2'd0, 8'h55}, '{1'b1, 2'd3, 8'hAA}, '{1'b1, 2'd0, 8'h0F},
        '{1'b1, 2'd1, 8'hF0}, '{1'b0, 2'd1, 8'hFF}, '{1'b1, 2'd3, 8'h01}, '{1'b0, 2'd2, 8'h00},
        '{1'b1, 2'd0, 8'h80}, '{1'b1, 2'd0, 8'h7E}, '{1'b0, 2'd3, 8'h12}, '{1'b0, 2'd0, 8'h34},
        '{1'b1, 2'd1, 8'h3C}, '{1'b1, 2'd2, 8'hC3}, '{1'b1, 2'd0, 8'h08}, '{1'b1, 2'd0, 8'hE7}
    };

    initial begin
        int id;
        int i_c [4];
        int i_z [3];
        int i_f [3];
        int i_g [8];
        int i_v0;
        int i_r0;

        for (int k = 0; k < HMAX; k++) hist[k] = IDLE;
        i_reset_n = 1'b0;
        i_de      = 1'b1;
        i_ctl     = 2'b11;
        i_data    = 8'hA5;

        // Reset held with live video on the inputs.
        repeat (3) begin
            @(posedge i_pix_clk);
            #2;
            check("reset_hold", o_word, 10'h354);
        end
        @(posedge i_pix_clk);
        #1;
        i_reset_n = 1'b1;
        check("reset_release", o_word, 10'h354);
        @(posedge i_pix_clk);
        #2;
        check("reset_release+1", o_word, 10'h354);

        send(1'b1, 2'd3, 8'hA5, id);
        for (int k = 0; k < 4; k++) send(1'b0, 2'(k), 8'hC3, i_c[k]);
        repeat (3) send(1'b0, 2'd0, 8'h5A, id);
        for (int k = 0; k < 3; k++) send(1'b1, 2'(2 - k), 8'h00, i_z[k]);
        repeat (3) send(1'b0, 2'd0, 8'h00, id);
        for (int k = 0; k < 3; k++) send(1'b1, 2'd1, 8'hFF, i_f[k]);
        repeat (3) send(1'b0, 2'd2, 8'h00, id);

        foreach (vec[k]) send(vec[k].de, vec[k].ctl, vec[k].data, id);
        for (int k = 0; k < 200; k++)
            send(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), id);

        // Asynchronous reset in the middle of a video period.
        send(1'b1, 2'd0, 8'h33, id);
        send(1'b1, 2'd0, 8'hC7, id);
        send(1'b1, 2'd0, 8'h0F, id);
        @(posedge i_pix_clk);
        #3;
        i_reset_n = 1'b0;
        #1;
        check("async_reset", o_word, 10'h354);
        @(posedge i_pix_clk);
        #1;
        i_de      = 1'b1;
        i_ctl     = 2'd0;
        i_data    = 8'h00;
        i_r0      = e;
        i_reset_n = 1'b1;

        repeat (2) send(1'b0, 2'd0, 8'h00, id);
        for (int k = 0; k < 8; k++) send(1'b0, 2'd0, 8'h99, i_g[k]);
        send(1'b1, 2'd0, 8'h00, i_v0);
        repeat (LAT + 2) send(1'b0, 2'd0, 8'h00, id);
        @(posedge i_pix_clk);
        @(negedge i_pix_clk);
        #1;

        check("ctl00", out_log[i_c[0] + LAT - 1], 10'h354);
        check("ctl01", out_log[i_c[1] + LAT - 1], 10'h0AB);
        check("ctl10", out_log[i_c[2] + LAT - 1], 10'h154);
        check("ctl11", out_log[i_c[3] + LAT - 1], 10'h2AB);
        check("zero_0", out_log[i_z[0] + LAT - 1], 10'h100);
        check("zero_1", out_log[i_z[1] + LAT - 1], 10'h3FF);
        check("zero_2", out_log[i_z[2] + LAT - 1], 10'h100);
        check("ff_0", out_log[i_f[0] + LAT - 1], 10'h200);
        check("ff_1", out_log[i_f[1] + LAT - 1], 10'h0FF);
        check("ff_2", out_log[i_f[2] + LAT - 1], 10'h0FF);
        check("after_reset", out_log[i_r0 + LAT - 1], 10'h100);
        for (int k = 0; k < 6; k++) check($sformatf("gap_ctl%0d", k), out_log[i_g[k] + LAT - 1], 10'h354);
        check("gap_ctl6", out_log[i_g[6] + LAT - 1], GUARD_EXP);
        check("gap_ctl7", out_log[i_g[7] + LAT - 1], GUARD_EXP);
        check("gap_video", out_log[i_v0 + LAT - 1], 10'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
